// File: rtl/tap_block_decoder_pkg.sv
// Shared definitions for the tape block decoder.
//  - Default tape timing (clk ticks) common with the pulse generator and saver.
//  - FSM state and half-period class encodings.
//  - Small saturating-increment helper for the block length counter.
package tap_block_decoder_pkg;

  localparam int LEADER_DEF     = 244;
  localparam int SYNC_DEF       = 73;
  localparam int ONE_DEF        = 195;
  localparam int ZERO_DEF       = 98;
  localparam int TOL_DEF        = 20;
  localparam int LEADER_MIN_DEF = 256;
  localparam int GAP_DEF        = LEADER_DEF + TOL_DEF + 50;
  localparam int CNT_W_DEF      = 10;
  localparam int FIFO_DEPTH_DEF = 16;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LEADER,
    ST_SYNC2,
    ST_BIT_H1,
    ST_BIT_H2
  } state_e;

  typedef enum logic [2:0] {
    CL_GLITCH,
    CL_SYN,
    CL_B0,
    CL_B1,
    CL_LDR,
    CL_GAPC
  } class_e;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/tap_block_decoder_if.sv
// Byte stream port of the tape block decoder (valid/ready, first-word-fall-through).
//  data  : head byte, 0 when valid is low
//  valid : data holds a byte
//  ready : consumer takes the byte when valid is also high
// master = decoder side, slave = consumer side.
interface tap_block_decoder_if;
  logic [7:0] data;
  logic       valid;
  logic       ready;

  modport master (output data, output valid, input ready);
  modport slave  (input data, input valid, output ready);
endinterface

// File: rtl/tap_block_decoder_byte_fifo.sv
// First-word-fall-through byte FIFO.
//  clk, rst_n : clock, asynchronous active-low reset (pointers only)
//  push_i/din_i, full_o  : write side; a push while full is dropped unless a pop frees the slot
//  pop_i/dout_o, empty_o : read side; dout_o shows the head entry, 0 when empty
module tap_block_decoder_byte_fifo #(
  parameter int DEPTH = 16,
  parameter int W     = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push_i,
  input  logic [W-1:0] din_i,
  output logic         full_o,
  input  logic         pop_i,
  output logic [W-1:0] dout_o,
  output logic         empty_o
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] mem_q [DEPTH];
  logic [AW:0]  wr_ptr_q, rd_ptr_q;
  logic         do_pop, do_push;

  // Extra pointer bit distinguishes full from empty when the indices match.
  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= din_i;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  assign dout_o = empty_o ? '0 : mem_q[rd_ptr_q[AW-1:0]];
endmodule

// File: rtl/tap_block_decoder.sv
// Tape block decoder: EAR half-wave stream -> TAP block bytes.
//  clk, rst_n    : tape tick clock, asynchronous active-low reset
//  ear_i         : raw EAR level (asynchronous)
//  dout_if       : byte stream out (FWFT valid/ready)
//  block_start_o : 1-cycle pulse when a block opens after sync
//  block_end_o   : 1-cycle pulse once a closed block has fully drained
//  block_len_o   : byte count of the last closed block
//  checksum_ok_o : last block had XOR 0, whole bytes only, no error, at least one byte
//  overflow_o    : sticky; dropped byte or rejected block, cleared by the next block_start
//  busy_o        : framing in progress, bytes buffered or an end pending
module tap_block_decoder
  import tap_block_decoder_pkg::*;
#(
  parameter int LEADER     = LEADER_DEF,
  parameter int SYNC       = SYNC_DEF,
  parameter int ONE        = ONE_DEF,
  parameter int ZERO       = ZERO_DEF,
  parameter int TOL        = TOL_DEF,
  parameter int LEADER_MIN = LEADER_MIN_DEF,
  parameter int GAP        = GAP_DEF,
  parameter int CNT_W      = CNT_W_DEF,
  parameter int FIFO_DEPTH = FIFO_DEPTH_DEF
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                ear_i,
  tap_block_decoder_if.master dout_if,
  output logic                block_start_o,
  output logic                block_end_o,
  output logic [15:0]         block_len_o,
  output logic                checksum_ok_o,
  output logic                overflow_o,
  output logic                busy_o
);
  localparam int LC_W = $clog2(LEADER_MIN);
  localparam logic [LC_W-1:0]  LC_LAST = LC_W'(LEADER_MIN - 1);
  localparam logic [CNT_W-1:0] TH_GAP  = CNT_W'(GAP);
  localparam logic [CNT_W-1:0] TH_LDR  = CNT_W'(LEADER - TOL);
  localparam logic [CNT_W-1:0] TH_B1   = CNT_W'(ONE - TOL);
  localparam logic [CNT_W-1:0] TH_B0   = CNT_W'(ZERO - TOL);
  localparam logic [CNT_W-1:0] TH_SYN  = CNT_W'(SYNC - TOL);

  logic ear_s1_q, ear_s2_q, ear_lvl_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  state_e state_q, state_d;
  class_e cls;
  logic [LC_W-1:0] ldr_cnt_q, ldr_cnt_d;
  logic        half_q, half_d;          // latched first half: 1 = B1, 0 = B0
  logic [6:0]  shreg_q, shreg_d;        // bits of the byte in progress
  logic [2:0]  nbits_q, nbits_d;
  logic [15:0] len_q, len_d, block_len_q, block_len_d;
  logic [7:0]  parity_q, parity_d, byte_w;
  logic err_q, err_d, pending_end_q, pending_end_d;
  logic checksum_ok_q, checksum_ok_d, overflow_q, overflow_d;
  logic block_start_q, block_start_d;
  logic edge_w, timeout, push, close, close_err, block_end;
  logic fifo_full, fifo_empty, fifo_pop;

  assign edge_w  = ear_s2_q ^ ear_lvl_q;
  assign timeout = !edge_w && (cnt_q == TH_GAP);
  assign cnt_d   = edge_w ? '0 : ((cnt_q == '1) ? cnt_q : cnt_q + 1'b1);

  // Largest class first, so a long half never falls into a shorter bin.
  always_comb begin
    if      (cnt_q > TH_GAP) cls = CL_GAPC;
    else if (cnt_q > TH_LDR) cls = CL_LDR;
    else if (cnt_q > TH_B1)  cls = CL_B1;
    else if (cnt_q > TH_B0)  cls = CL_B0;
    else if (cnt_q > TH_SYN) cls = CL_SYN;
    else                     cls = CL_GLITCH;
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ear_s1_q <= 1'b0; ear_s2_q <= 1'b0; ear_lvl_q <= 1'b0;
      cnt_q <= '0; state_q <= ST_IDLE; ldr_cnt_q <= '0;
      half_q <= 1'b0; shreg_q <= '0; nbits_q <= '0;
      len_q <= '0; parity_q <= '0; err_q <= 1'b0;
      pending_end_q <= 1'b0; block_len_q <= '0; checksum_ok_q <= 1'b0;
      overflow_q <= 1'b0; block_start_q <= 1'b0;
    end else begin
      ear_s1_q <= ear_i; ear_s2_q <= ear_s1_q; ear_lvl_q <= ear_s2_q;
      cnt_q <= cnt_d; state_q <= state_d; ldr_cnt_q <= ldr_cnt_d;
      half_q <= half_d; shreg_q <= shreg_d; nbits_q <= nbits_d;
      len_q <= len_d; parity_q <= parity_d; err_q <= err_d;
      pending_end_q <= pending_end_d; block_len_q <= block_len_d;
      checksum_ok_q <= checksum_ok_d; overflow_q <= overflow_d;
      block_start_q <= block_start_d;
    end
  end

  // Next state and block bookkeeping.
  always_comb begin
    state_d = state_q; ldr_cnt_d = ldr_cnt_q; half_d = half_q;
    shreg_d = shreg_q; nbits_d = nbits_q; len_d = len_q; parity_d = parity_q;
    err_d = err_q; pending_end_d = pending_end_q && !block_end;
    block_len_d = block_len_q; checksum_ok_d = checksum_ok_q; overflow_d = overflow_q;
    block_start_d = 1'b0; push = 1'b0; close = 1'b0; close_err = 1'b0;
    byte_w = {shreg_q, half_q};
    case (state_q)
      ST_IDLE: if (edge_w) begin
        if (cls == CL_LDR) begin
          if (ldr_cnt_q == LC_LAST) begin
            ldr_cnt_d = '0;
            state_d   = ST_LEADER;
          end else begin
            ldr_cnt_d = ldr_cnt_q + 1'b1;
          end
        end else begin
          ldr_cnt_d = '0;
        end
      end
      ST_LEADER: if (edge_w) begin
        if (cls == CL_SYN)      state_d = ST_SYNC2;
        else if (cls != CL_LDR) state_d = ST_IDLE;
      end else if (timeout) begin
        state_d = ST_IDLE;
      end
      ST_SYNC2: if (edge_w) begin
        // A block still waiting to drain keeps the new one from opening.
        if (cls == CL_SYN && !pending_end_q) begin
          state_d = ST_BIT_H1; block_start_d = 1'b1;
          len_d = '0; parity_d = '0; nbits_d = '0; err_d = 1'b0; overflow_d = 1'b0;
        end else begin
          state_d = ST_IDLE;
          if (cls == CL_SYN) overflow_d = 1'b1;
        end
      end else if (timeout) begin
        state_d = ST_IDLE;
      end
      ST_BIT_H1: if (edge_w) begin
        if (cls == CL_B1 || cls == CL_B0) begin
          half_d  = (cls == CL_B1);
          state_d = ST_BIT_H2;
        end else begin
          close = 1'b1; close_err = 1'b1;
        end
      end else if (timeout) begin
        close = 1'b1;
      end
      ST_BIT_H2: if (edge_w) begin
        if ((cls == CL_B1 && half_q) || (cls == CL_B0 && !half_q)) begin
          shreg_d = byte_w[6:0];
          nbits_d = nbits_q + 1'b1;
          state_d = ST_BIT_H1;
          if (nbits_q == 3'd7) begin
            parity_d = parity_q ^ byte_w;
            len_d    = sat_inc16(len_q);
            // A pop in the same cycle frees a slot, so full alone is not an overflow.
            if (fifo_full && !fifo_pop) begin
              overflow_d = 1'b1; err_d = 1'b1;
            end else begin
              push = 1'b1;
            end
          end
        end else begin
          close = 1'b1; close_err = 1'b1;
        end
      end else if (timeout) begin
        close = 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase
    // Close uses the post-byte values so a byte finished this cycle is counted.
    if (close) begin
      block_len_d   = len_d;
      checksum_ok_d = (parity_d == '0) && (nbits_d == '0) && !err_d && !close_err &&
                      (len_d != '0);
      pending_end_d = 1'b1;
      state_d       = ST_IDLE;
    end
  end

  // Outputs.
  always_comb begin
    block_end = pending_end_q && fifo_empty;
    busy_o    = (state_q != ST_IDLE) || !fifo_empty || pending_end_q;
  end

  assign fifo_pop      = dout_if.valid && dout_if.ready;
  assign dout_if.valid = !fifo_empty;
  assign block_end_o   = block_end;
  assign block_start_o = block_start_q;
  assign block_len_o   = block_len_q;
  assign checksum_ok_o = checksum_ok_q;
  assign overflow_o    = overflow_q;

  tap_block_decoder_byte_fifo #(.DEPTH(FIFO_DEPTH), .W(8)) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (push),
    .din_i   (byte_w),
    .full_o  (fifo_full),
    .pop_i   (fifo_pop),
    .dout_o  (dout_if.data),
    .empty_o (fifo_empty)
  );
endmodule

// File: tb/tb_tap_block_decoder.sv
// Bench for tap_block_decoder, run with shortened tape timing so each block is a few
// thousand ticks. Expected results come from the block contents (bytes, leader length,
// corruption point) rather than from the decoder's internals.
module tb_tap_block_decoder;
  localparam int P_LDR = 40, P_SYN = 12, P_ONE = 32, P_ZERO = 16, P_TOL = 4;
  localparam int P_LMIN = 16, P_GAP = 54, P_DEPTH = 16, N_LDR = 20, END_GAP = 80;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic ear = 1'b0;
  logic block_start, block_end, checksum_ok, overflow, busy;
  logic [15:0] block_len;

  tap_block_decoder_if dif();

  tap_block_decoder #(
    .LEADER(P_LDR), .SYNC(P_SYN), .ONE(P_ONE), .ZERO(P_ZERO), .TOL(P_TOL),
    .LEADER_MIN(P_LMIN), .GAP(P_GAP), .CNT_W(10), .FIFO_DEPTH(P_DEPTH)
  ) dut (
    .clk(clk), .rst_n(rst_n), .ear_i(ear), .dout_if(dif),
    .block_start_o(block_start), .block_end_o(block_end), .block_len_o(block_len),
    .checksum_ok_o(checksum_ok), .overflow_o(overflow), .busy_o(busy)
  );

  always #5 clk = ~clk;

  int n_vec = 0, n_err = 0;
  int n_start = 0, n_end = 0, end_len = 0, end_ok = 0, end_got = 0;
  logic [7:0] got_q[$];

  // Observer: popped bytes and block events, sampled mid-cycle.
  always @(negedge clk) begin
    if (dif.valid && dif.ready) got_q.push_back(dif.data);
    if (block_start) n_start++;
    if (block_end) begin
      n_end++;
      end_len = int'(block_len);
      end_ok  = int'(checksum_ok);
      end_got = got_q.size();
    end
  end

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation did not finish, time %0t, required earlier", $time);
    $fatal(1);
  end

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d (0x%0h), want %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  task automatic half(input int p);
    ear = ~ear;
    repeat (p) @(posedge clk);
    #1;
  endtask

  task automatic send_leader(input int n);
    for (int i = 0; i < n; i++) half(P_LDR);
  endtask

  task automatic send_sync();
    half(P_SYN);
    half(P_SYN);
  endtask

  task automatic send_byte(input logic [7:0] b);
    for (int i = 7; i >= 0; i--) begin
      half(b[i] ? P_ONE : P_ZERO);
      half(b[i] ? P_ONE : P_ZERO);
    end
  endtask

  // corrupt = index of the bit whose second half has the wrong length (-1: none).
  task automatic send_block(input int nldr, input logic [7:0] b[$], input int corrupt);
    int k;
    k = 0;
    send_leader(nldr);
    send_sync();
    foreach (b[j]) begin
      for (int i = 7; i >= 0; i--) begin
        if (k == corrupt) begin
          half(b[j][i] ? P_ONE : P_ZERO);
          half(b[j][i] ? P_ZERO : P_ONE);
          half(END_GAP);
          return;
        end
        half(b[j][i] ? P_ONE : P_ZERO);
        half(b[j][i] ? P_ONE : P_ZERO);
        k++;
      end
    end
    half(END_GAP);
  endtask

  task automatic wait_end(input int e0, input string name);
    int cyc;
    cyc = 0;
    while (n_end == e0 && cyc < 2000) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    chk({name, ".end_seen"}, n_end - e0, 1);
  endtask

  task automatic check_block(input string name, input int s0, input int e0, input int g0,
                             input int x_start, input int x_end, input int x_len,
                             input int x_ok, input int x_ovf, input logic [7:0] xb[$]);
    if (x_end != 0) begin
      wait_end(e0, name);
      chk({name, ".len"}, end_len, x_len);
      chk({name, ".checksum_ok"}, end_ok, x_ok);
      chk({name, ".bytes_at_end"}, end_got - g0, xb.size());
    end else begin
      repeat (100) @(posedge clk);
      #1;
      chk({name, ".ends"}, n_end - e0, 0);
    end
    chk({name, ".starts"}, n_start - s0, x_start);
    chk({name, ".overflow"}, int'(overflow), x_ovf);
    chk({name, ".nbytes"}, got_q.size() - g0, xb.size());
    for (int i = 0; i < xb.size() && g0 + i < got_q.size(); i++)
      chk($sformatf("%s.byte%0d", name, i), int'(got_q[g0 + i]), int'(xb[i]));
    $display("block %s: starts=%0d ends=%0d len=%0d ok=%0d bytes=%0d ovf=%0d", name,
             n_start - s0, n_end - e0, end_len, end_ok, got_q.size() - g0, overflow);
  endtask

  typedef struct {
    int         nldr;
    int         nb;
    logic [7:0] b0, b1, b2;
    int         corrupt;
    bit         rdy;
    int         x_start, x_end, x_len, x_ok, x_nout;
  } vec_t;

  vec_t vt[10];
  logic [7:0] bq[$], xb[$];
  logic [7:0] xr;
  int s0, e0, g0, nb, corrupt, nout, xok;

  initial begin
    vt[0] = '{N_LDR, 3, 8'h00, 8'h05, 8'h05, -1, 1'b1, 1, 1, 3, 1, 3}; // good block
    vt[1] = '{N_LDR, 2, 8'hFF, 8'h01, 8'h00, -1, 1'b1, 1, 1, 2, 0, 2}; // bad checksum
    vt[2] = '{10,    3, 8'h00, 8'h05, 8'h05, -1, 1'b1, 0, 0, 0, 0, 0}; // leader too short
    vt[3] = '{N_LDR, 2, 8'hA5, 8'h3C, 8'h00, 11, 1'b1, 1, 1, 1, 0, 1}; // half mismatch mid-byte
    vt[4] = '{N_LDR, 1, 8'h00, 8'h00, 8'h00, -1, 1'b1, 1, 1, 1, 1, 1}; // single zero byte
    vt[5] = '{N_LDR, 0, 8'h00, 8'h00, 8'h00, -1, 1'b1, 1, 1, 0, 0, 0}; // empty block
    vt[6] = '{N_LDR, 3, 8'h11, 8'h22, 8'h33, -1, 1'b0, 1, 1, 3, 1, 3}; // consumer stalled
    vt[7] = '{N_LDR, 1, 8'h80, 8'h00, 8'h00, 0,  1'b1, 1, 1, 0, 0, 0}; // mismatch on first bit
    vt[8] = '{P_LMIN, 2, 8'h5A, 8'h5A, 8'h00, -1, 1'b1, 1, 1, 2, 1, 2}; // exactly minimum leader
    vt[9] = '{P_LMIN - 1, 2, 8'h5A, 8'h5A, 8'h00, -1, 1'b1, 0, 0, 0, 0, 0}; // one short

    // Reset with ear toggling: everything quiet.
    dif.ready = 1'b0;
    rst_n = 1'b0;
    repeat (20) begin
      @(posedge clk);
      #1;
      ear = ~ear;
    end
    chk("rst.valid", int'(dif.valid), 0);
    chk("rst.data", int'(dif.data), 0);
    chk("rst.block_start", int'(block_start), 0);
    chk("rst.block_end", int'(block_end), 0);
    chk("rst.block_len", int'(block_len), 0);
    chk("rst.checksum_ok", int'(checksum_ok), 0);
    chk("rst.overflow", int'(overflow), 0);
    chk("rst.busy", int'(busy), 0);
    rst_n = 1'b1;
    repeat (100) @(posedge clk);
    #1;
    chk("rel.busy", int'(busy), 0);
    chk("rel.valid", int'(dif.valid), 0);

    // Backpressure: 20 bytes into a 16-deep FIFO.
    s0 = n_start; e0 = n_end; g0 = got_q.size();
    dif.ready = 1'b0;
    bq = {};
    for (int i = 0; i < 20; i++) bq.push_back(8'(i * 13 + 7));
    send_block(N_LDR, bq, -1);
    repeat (50) @(posedge clk);
    #1;
    chk("bp.no_end_while_stalled", n_end - e0, 0);
    chk("bp.overflow_before_drain", int'(overflow), 1);
    xb = {};
    for (int i = 0; i < P_DEPTH; i++) xb.push_back(bq[i]);
    dif.ready = 1'b1;
    check_block("bp", s0, e0, g0, 1, 1, 20, 0, 1, xb);

    // A block arriving while the previous one still waits to drain is rejected.
    s0 = n_start; e0 = n_end; g0 = got_q.size();
    dif.ready = 1'b0;
    bq = {8'h12, 8'h12};
    send_block(N_LDR, bq, -1);
    bq = {8'h34};
    send_block(N_LDR, bq, -1);
    chk("pend.starts_before_drain", n_start - s0, 1);
    chk("pend.overflow", int'(overflow), 1);
    dif.ready = 1'b1;
    xb = {8'h12, 8'h12};
    check_block("pend", s0, e0, g0, 1, 1, 2, 1, 1, xb);

    // Table of directed blocks.
    for (int v = 0; v < 10; v++) begin
      s0 = n_start; e0 = n_end; g0 = got_q.size();
      bq = {};
      if (vt[v].nb > 0) bq.push_back(vt[v].b0);
      if (vt[v].nb > 1) bq.push_back(vt[v].b1);
      if (vt[v].nb > 2) bq.push_back(vt[v].b2);
      xb = {};
      for (int i = 0; i < vt[v].x_nout; i++) xb.push_back(bq[i]);
      dif.ready = vt[v].rdy;
      send_block(vt[v].nldr, bq, vt[v].corrupt);
      dif.ready = 1'b1;
      check_block($sformatf("vec%0d", v), s0, e0, g0, vt[v].x_start, vt[v].x_end,
                  vt[v].x_len, vt[v].x_ok, 0, xb);
    end

    // Reset in the middle of the third byte.
    e0 = n_end; g0 = got_q.size();
    dif.ready = 1'b0;
    send_leader(N_LDR);
    send_sync();
    send_byte(8'h5A);
    send_byte(8'hC3);
    half(P_ONE);
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("midrst.valid", int'(dif.valid), 0);
    chk("midrst.busy", int'(busy), 0);
    chk("midrst.block_len", int'(block_len), 0);
    rst_n = 1'b1;
    dif.ready = 1'b1;
    repeat (100) @(posedge clk);
    #1;
    chk("midrst.no_end", n_end - e0, 0);
    chk("midrst.no_bytes", got_q.size() - g0, 0);
    s0 = n_start; e0 = n_end; g0 = got_q.size();
    bq = {8'h00, 8'h05, 8'h05};
    send_block(N_LDR, bq, -1);
    check_block("after_rst", s0, e0, g0, 1, 1, 3, 1, 0, bq);

    // Random blocks checked against the block-content model.
    for (int r = 0; r < 8; r++) begin
      s0 = n_start; e0 = n_end; g0 = got_q.size();
      nb = $urandom_range(0, 5);
      bq = {};
      xr = 8'h00;
      for (int i = 0; i < nb; i++) begin
        bq.push_back(8'($urandom_range(0, 255)));
        xr = xr ^ bq[i];
      end
      corrupt = -1;
      if (nb > 0 && $urandom_range(0, 1) == 1) bq.push_back(xr);
      else if (nb > 0 && $urandom_range(0, 2) == 0) corrupt = $urandom_range(0, 8 * nb - 1);
      nout = (corrupt < 0) ? bq.size() : corrupt / 8;
      xb = {};
      xr = 8'h00;
      for (int i = 0; i < nout; i++) begin
        xb.push_back(bq[i]);
        xr = xr ^ bq[i];
      end
      xok = (corrupt < 0 && nout > 0 && xr == 8'h00) ? 1 : 0;
      dif.ready = 1'($urandom_range(0, 1));
      send_block(N_LDR, bq, corrupt);
      dif.ready = 1'b1;
      check_block($sformatf("rand%0d", r), s0, e0, g0, 1, 1, nout, xok, 0, xb);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
